// File: rtl/eth_tx_pad.sv
// Zero-pads short Ethernet TX frames up to MIN_FRAME_BYTES (pre-FCS) and passes
// longer frames through untouched, behind a single registered AXI-Stream output slice.
module eth_tx_pad #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [AXIS_DATA_WIDTH-1:0]   tx_frame_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] tx_frame_tkeep,
    input  logic                         tx_frame_tvalid,
    input  logic                         tx_frame_tlast,
    input  logic                         tx_frame_tuser,
    output logic                         tx_frame_tready,
    output logic [AXIS_DATA_WIDTH-1:0]   tx_pad_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] tx_pad_tkeep,
    output logic                         tx_pad_tvalid,
    output logic                         tx_pad_tlast,
    output logic                         tx_pad_tuser,
    input  logic                         tx_pad_tready
);

    localparam int          KW    = AXIS_DATA_WIDTH / 8;
    localparam logic [16:0] MIN17 = 17'(MIN_FRAME_BYTES);
    localparam logic [16:0] KW17  = 17'(KW);

    typedef enum logic {
        PASS = 1'b0,
        PAD  = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [15:0]                  cnt_q, cnt_d;
    logic                         err_q, err_d;
    logic                         ready_en_q, ready_en_d;
    logic [AXIS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [KW-1:0]                tkeep_q, tkeep_d;
    logic                         tvalid_q, tvalid_d;
    logic                         tlast_q, tlast_d;
    logic                         tuser_q, tuser_d;

    logic [AXIS_DATA_WIDTH-1:0]   data_masked;
    logic [16:0]                  beat_bytes;
    logic [16:0]                  total;
    logic [16:0]                  cnt_plus_w;
    logic [16:0]                  rem;
    logic                         load;
    logic                         accept;

    function automatic logic [KW-1:0] low_mask(input logic [16:0] n);
        logic [KW-1:0] m;
        for (int i = 0; i < KW; i++) begin
            m[i] = (17'(i) < n);
        end
        return m;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] b);
        logic [17:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s > 18'h0FFFF) ? 16'hFFFF : s[15:0];
    endfunction

    // Bytes beyond the valid lanes of a short last beat become padding, so clear them.
    generate
        for (genvar gi = 0; gi < KW; gi++) begin : g_mask
            assign data_masked[gi*8 +: 8] = tx_frame_tkeep[gi] ? tx_frame_tdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KW; i++) begin
            beat_bytes = beat_bytes + 17'(tx_frame_tkeep[i]);
        end
    end

    assign total      = {1'b0, cnt_q} + beat_bytes;
    assign cnt_plus_w = {1'b0, cnt_q} + KW17;
    assign rem        = MIN17 - {1'b0, cnt_q};

    assign load            = !tvalid_q || tx_pad_tready;
    assign tx_frame_tready = ready_en_q && (state_q == PASS) && load;
    assign accept          = tx_frame_tvalid && tx_frame_tready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ready_en_d = 1'b1;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tuser_d    = tuser_q;

        if (load) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            PASS: begin
                if (accept) begin
                    tvalid_d = 1'b1;
                    tuser_d  = 1'b0;
                    if (!tx_frame_tlast) begin
                        tdata_d = tx_frame_tdata;
                        tkeep_d = tx_frame_tkeep;
                        tlast_d = 1'b0;
                        cnt_d   = sat_add(cnt_q, beat_bytes);
                        err_d   = err_q | tx_frame_tuser;
                    end else if (total >= MIN17) begin
                        tdata_d = tx_frame_tdata;
                        tkeep_d = tx_frame_tkeep;
                        tlast_d = 1'b1;
                        tuser_d = err_q | tx_frame_tuser;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end else begin
                        tdata_d = data_masked;
                        tkeep_d = (cnt_plus_w <= MIN17) ? '1 : low_mask(rem);
                        if (cnt_plus_w >= MIN17) begin
                            tlast_d = 1'b1;
                            tuser_d = err_q | tx_frame_tuser;
                            cnt_d   = '0;
                            err_d   = 1'b0;
                        end else begin
                            // Counter now tracks output bytes, including the zeroed tail of this beat.
                            tlast_d = 1'b0;
                            cnt_d   = cnt_plus_w[15:0];
                            err_d   = err_q | tx_frame_tuser;
                            state_d = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (load) begin
                    tvalid_d = 1'b1;
                    tdata_d  = '0;
                    if (rem > KW17) begin
                        tkeep_d = '1;
                        tlast_d = 1'b0;
                        tuser_d = 1'b0;
                        cnt_d   = cnt_plus_w[15:0];
                    end else begin
                        tkeep_d = low_mask(rem);
                        tlast_d = 1'b1;
                        tuser_d = err_q;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = PASS;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= PASS;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ready_en_q <= ready_en_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
        end
    end

    assign tx_pad_tdata  = tdata_q;
    assign tx_pad_tkeep  = tkeep_q;
    assign tx_pad_tvalid = tvalid_q;
    assign tx_pad_tlast  = tlast_q;
    assign tx_pad_tuser  = tuser_q;

endmodule

// File: tb/tb_eth_tx_pad.sv
// Randomised scoreboard bench for eth_tx_pad: frames are modelled as byte counts padded
// up to the minimum length and chunked into output beats.
module tb_eth_tx_pad;

    localparam int W   = 64;
    localparam int KB  = W / 8;
    localparam int MIN = 60;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [KB-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [W-1:0]  tx_frame_tdata = '0;
    logic [KB-1:0] tx_frame_tkeep = '0;
    logic          tx_frame_tvalid = 1'b0;
    logic          tx_frame_tlast = 1'b0;
    logic          tx_frame_tuser = 1'b0;
    logic          tx_frame_tready;
    logic [W-1:0]  tx_pad_tdata;
    logic [KB-1:0] tx_pad_tkeep;
    logic          tx_pad_tvalid;
    logic          tx_pad_tlast;
    logic          tx_pad_tuser;
    logic          tx_pad_tready = 1'b1;

    int    checks = 0;
    int    errors = 0;
    int    pops = 0;
    int    frame_no = 0;
    bit    rand_ready = 1'b0;
    bit    pad_active = 1'b0;
    beat_t exp_q[$];

    eth_tx_pad #(
        .AXIS_DATA_WIDTH(W),
        .MIN_FRAME_BYTES(MIN)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .tx_frame_tdata(tx_frame_tdata),
        .tx_frame_tkeep(tx_frame_tkeep),
        .tx_frame_tvalid(tx_frame_tvalid),
        .tx_frame_tlast(tx_frame_tlast),
        .tx_frame_tuser(tx_frame_tuser),
        .tx_frame_tready(tx_frame_tready),
        .tx_pad_tdata(tx_pad_tdata),
        .tx_pad_tkeep(tx_pad_tkeep),
        .tx_pad_tvalid(tx_pad_tvalid),
        .tx_pad_tlast(tx_pad_tlast),
        .tx_pad_tuser(tx_pad_tuser),
        .tx_pad_tready(tx_pad_tready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 2000000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            tx_pad_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    // Scoreboard side: pops expected beats on each output handshake, checks stall stability
    // and that no input is accepted while padding is in progress.
    task automatic monitor();
        beat_t got, e, prev;
        bit    prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            got = '{tx_pad_tdata, tx_pad_tkeep, tx_pad_tlast, tx_pad_tuser};
            if (!rstn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!tx_pad_tvalid || got !== prev) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%0b beat=%h required valid=1 beat=%h",
                                 tx_pad_tvalid, got, prev);
                    end
                end
                if (pad_active) begin
                    if (tx_pad_tvalid && tx_pad_tlast) begin
                        pad_active = 1'b0;
                    end else begin
                        checks++;
                        if (tx_frame_tready !== 1'b0) begin
                            errors++;
                            $display("FAIL pad_tready: got tx_frame_tready=%0b required 0", tx_frame_tready);
                        end
                    end
                end
                if (tx_pad_tvalid && tx_pad_tready) begin
                    checks++;
                    pops++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: got data=%h keep=%h last=%0b user=%0b required none",
                                 got.data, got.keep, got.last, got.user);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL out_beat: got data=%h keep=%h last=%0b user=%0b required data=%h keep=%h last=%0b user=%0b",
                                     got.data, got.keep, got.last, got.user, e.data, e.keep, e.last, e.user);
                        end
                    end
                end
                prev_stall = tx_pad_tvalid && !tx_pad_tready;
                prev = got;
            end
        end
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic [KB-1:0] k,
                             input logic last, input logic user);
        bit ok;
        tx_frame_tdata  = d;
        tx_frame_tkeep  = k;
        tx_frame_tlast  = last;
        tx_frame_tuser  = user;
        tx_frame_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (tx_frame_tready) ok = 1'b1;
        end
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got tx_frame_tready=0 for 3000 cycles required 1");
        end
        tick();
        tx_frame_tvalid = 1'b0;
        tx_frame_tlast  = 1'b0;
        tx_frame_tuser  = 1'b0;
        checks++;
        if (ok && tx_pad_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL latency: got tx_pad_tvalid=%0b one cycle after accept required 1", tx_pad_tvalid);
        end
    endtask

    // Model: data beats pass as-is; a frame under MIN is continued from its last beat with
    // zero bytes until MIN bytes have been emitted, one W/8-byte beat at a time.
    task automatic send_frame(input int len, input int user_beat, input bit gaps);
        logic [W-1:0]  d[$];
        logic [KB-1:0] k[$];
        beat_t         b;
        int            n, lastb, cnt_prev, rem, nb, beats_out;
        logic          err;
        bit            first, needs_pad;
        n = (len == 0) ? 1 : (len + KB - 1) / KB;
        lastb = len - KB * (n - 1);
        cnt_prev = KB * (n - 1);
        err = (user_beat >= 0 && user_beat < n);
        for (int i = 0; i < n; i++) begin
            d.push_back({$urandom, $urandom});
            k.push_back((i < n - 1) ? {KB{1'b1}} : KB'((1 << lastb) - 1));
        end
        beats_out = 0;
        for (int i = 0; i < n - 1; i++) begin
            b = '{d[i], k[i], 1'b0, 1'b0};
            exp_q.push_back(b);
            beats_out++;
        end
        if (len >= MIN) begin
            b = '{d[n-1], k[n-1], 1'b1, err};
            exp_q.push_back(b);
            beats_out++;
        end else begin
            rem = MIN - cnt_prev;
            first = 1'b1;
            while (rem > 0) begin
                nb = (rem > KB) ? KB : rem;
                b.data = '0;
                if (first) begin
                    for (int j = 0; j < lastb; j++) b.data[j*8 +: 8] = d[n-1][j*8 +: 8];
                end
                b.keep = KB'((1 << nb) - 1);
                b.last = (rem <= KB);
                b.user = (rem <= KB) ? err : 1'b0;
                exp_q.push_back(b);
                beats_out++;
                rem -= nb;
                first = 1'b0;
            end
        end
        needs_pad = (len < MIN) && (cnt_prev + KB < MIN);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_beat(d[i], k[i], (i == n - 1), (i == user_beat));
        end
        if (needs_pad) pad_active = 1'b1;
        $display("frame %0d: len=%0d beats_in=%0d beats_out=%0d user=%0b", frame_no, len, n, beats_out, err);
        frame_no++;
    endtask

    task automatic drain();
        int budget;
        budget = 5000;
        while ((exp_q.size() != 0 || pad_active) && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding required 0", exp_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (tx_pad_tvalid !== 1'b0 || tx_pad_tlast !== 1'b0 || tx_pad_tuser !== 1'b0 ||
            tx_pad_tkeep !== '0 || tx_pad_tdata !== '0 || tx_frame_tready !== 1'b0) begin
            errors++;
            $display("FAIL %s: got valid=%0b last=%0b user=%0b keep=%h data=%h frame_tready=%0b required all 0",
                     name, tx_pad_tvalid, tx_pad_tlast, tx_pad_tuser, tx_pad_tkeep, tx_pad_tdata, tx_frame_tready);
        end
    endtask

    task automatic check_frame_ready(input string name, input logic req);
        checks++;
        if (tx_frame_tready !== req) begin
            errors++;
            $display("FAIL %s: got tx_frame_tready=%0b required %0b", name, tx_frame_tready, req);
        end
    endtask

    initial begin
        int p0, budget, len;
        fork
            monitor();
            ready_driver();
        join_none

        #2;
        check_outputs_zero("reset_outputs");
        #5;
        check_outputs_zero("reset_held");
        rstn = 1'b1;
        #1;
        check_frame_ready("ready_before_clock", 1'b0);
        tick();
        check_frame_ready("ready_after_clock", 1'b1);

        send_frame(14, -1, 1'b0);
        drain();
        send_frame(60, -1, 1'b0);
        drain();
        send_frame(1500, -1, 1'b0);
        drain();
        send_frame(14, 0, 1'b0);
        send_frame(14, -1, 1'b0);
        drain();
        send_frame(0, -1, 1'b0);
        drain();

        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(61, 300)) : int'($urandom_range(0, 80));
            send_frame(len, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1, 1'($urandom_range(0, 1)));
        end
        drain();

        // Abort a frame while padding is in progress.
        rand_ready = 1'b0;
        tick();
        p0 = pops;
        send_frame(14, -1, 1'b0);
        budget = 200;
        while (pops < p0 + 4 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL pad_progress: got %0d beats required 4", pops - p0);
        end
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();
        pad_active = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        check_frame_ready("ready_after_reset_release", 1'b0);
        tick();
        check_frame_ready("ready_after_reset_clock", 1'b1);
        send_frame(60, -1, 1'b0);
        drain();
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_pad.md
Name: eth_tx_pad

Overview:
- Sits directly downstream of the Ethernet TX frame generator, between its frame output stream and the MAC TX AXI-Stream input.
- Guarantees every frame leaving the block is at least MIN_FRAME_BYTES long (header + payload, before FCS). Short frames are zero-padded; longer frames pass through unchanged.
- Provides a registered output slice with backpressure support.

Parameters:
- AXIS_DATA_WIDTH, 64, stream data width in bits; multiple of 8, 32..512.
- MIN_FRAME_BYTES, 60, minimum output frame length in bytes; must be ≥ AXIS_DATA_WIDTH/8.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- tx_frame_tdata  input  AXIS_DATA_WIDTH  frame data in; byte 0 in bits [7:0]
- tx_frame_tkeep  input  AXIS_DATA_WIDTH/8  byte enables; contiguous from bit 0
- tx_frame_tvalid  input  1  input beat valid
- tx_frame_tlast  input  1  last beat of frame
- tx_frame_tuser  input  1  frame error flag
- tx_frame_tready  output  1  input ready
- tx_pad_tdata  output  AXIS_DATA_WIDTH  padded frame data
- tx_pad_tkeep  output  AXIS_DATA_WIDTH/8  output byte enables
- tx_pad_tvalid  output  1  output beat valid
- tx_pad_tlast  output  1  last beat of output frame
- tx_pad_tuser  output  1  error flag; valid only on the tlast beat
- tx_pad_tready  input  1  downstream ready

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rstn; the block is clocked on clk.
- Reset values:
  - all tx_pad_* outputs = 0
  - tx_frame_tready = 0 while rstn is low, then 1 from the first clock after release
  - state = PASS, byte counter = 0, sticky error flag = 0
- Output register:
  - It loads when (!tx_pad_tvalid || tx_pad_tready).
  - Latency is 1 cycle from an accepted input beat to tx_pad_tvalid.
  - The output holds stable while tvalid && !tready.
- tx_frame_tready = (state == PASS) && (!tx_pad_tvalid || tx_pad_tready). Input is never accepted during PAD.
- Counters:
  - cnt is 16-bit and counts frame bytes accepted so far.
  - beat_bytes = popcount(tkeep).
  - cnt saturates at 0xFFFF; padding is irrelevant once cnt ≥ MIN_FRAME_BYTES.
- Sticky error: err = err | tuser on every accepted beat. It is cleared when the output tlast beat is loaded.
- PASS state, on an accepted beat with tlast = 0: copy the beat to output, tlast = 0, cnt += beat_bytes.
- PASS state, on an accepted beat with tlast = 1, where total = cnt + beat_bytes:
  - total ≥ MIN_FRAME_BYTES: copy the beat; tlast = 1; tuser = err | tuser; cnt = 0; stay in PASS.
  - total < MIN_FRAME_BYTES: zero bytes above beat_bytes in tdata. Set tkeep = all-ones if (cnt + W/8) ≤ MIN_FRAME_BYTES, else keep (MIN_FRAME_BYTES − cnt) low bytes. tlast = 1 only if cnt + W/8 ≥ MIN_FRAME_BYTES. Otherwise cnt += W/8 and go to PAD.
- PAD state: each time the output register loads, emit tdata = 0.
  - If MIN_FRAME_BYTES − cnt > W/8: emit tkeep = all-ones, tlast = 0, cnt += W/8.
  - Otherwise: emit tkeep = (MIN_FRAME_BYTES − cnt) low bytes set, tlast = 1, tuser = err; cnt = 0; go to PASS.
- Padding bytes are always 0x00. Data bytes are never reordered.
- A single-beat frame with tkeep = 0 counts as 0 bytes and is padded to the full minimum.
- Non-contiguous tkeep: behaviour is undefined; no checking is performed.
- Reset asserted mid-frame or mid-PAD: all state is dropped immediately and the partial frame is abandoned. No tlast is produced for it.

Test Plan:
- 64-bit, 14-byte frame (tkeep 0xFF, then 0x03 with tlast), tready = 1 → 8 output beats.
  - Beat 2: keep 0xFF, bytes 14–15 = 0.
  - Beats 3–7: zero data, keep 0xFF.
  - Beat 8: keep 0x0F, tlast.
  - Total 60 bytes; first output 1 cycle after first input.
- 60-byte frame (7 × 0xFF, then 0x0F with tlast) → passed through bit-exact; tlast on beat 8; no extra beats.
- 1500-byte frame → passed through unchanged; cnt saturation not reached; final keep 0x0F.
- 14-byte frame with tuser = 1 on beat 1 only → tuser = 1 only on output beat 8 (the tlast beat); the next frame has tuser = 0.
- Random tx_pad_tready toggling (50%) across back-to-back short and long frames → no lost or duplicated beats; tdata/tkeep stable while stalled; tx_frame_tready = 0 throughout PAD.
- rstn pulsed low during PAD beat 4 → outputs 0 asynchronously. After release, a fresh 60-byte frame passes through correctly with cnt starting from 0.
